// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR defaults, stream FSM states and the single-step function.
package lfsr_pkg;

    localparam int          MAX_W     = 64;
    localparam int          DEF_WIDTH = 32;
    localparam logic [31:0] DEF_TAPS  = 32'h088C8892;
    localparam logic [31:0] DEF_SEED  = 32'd12403728;

    typedef enum logic {IDLE, RUN} state_e;

    // Generic over width: operands are zero-extended to MAX_W and the result masked back to width bits.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int unsigned width);
        return ((s << 1) | MAX_W'(^(s & taps))) & ((MAX_W'(1) << width) - MAX_W'(1));
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// lfsr_advance: purely combinational chain of STEPS Fibonacci LFSR steps.
module lfsr_advance
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter int               STEPS = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] chain [STEPS+1];

    assign chain[0] = cur;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        assign chain[i+1] = WIDTH'(lfsr_next(MAX_W'(chain[i]), MAX_W'(TAPS), WIDTH));
    end

    assign nxt = chain[STEPS];

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: LFSR pseudo-random word source with valid/ready output,
// runtime seed load, zero-lockup recovery and an accepted-word counter.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter int               STEPS = 1,
    parameter int               OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             seed_we_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             lockup_o,
    output logic [31:0]      count_o,
    output logic [WIDTH-1:0] state_o
);

    state_e           fsm, fsm_nxt;
    logic [WIDTH-1:0] lfsr, adv, cand;
    logic             xfer, wr, zero;

    lfsr_advance #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS)) u_adv (
        .cur(lfsr),
        .nxt(adv)
    );

    // A seed load wins over a coincident transfer; the transfer is still consumed.
    always_comb begin
        fsm_nxt = en_i ? RUN : IDLE;
        xfer    = valid_o & ready_i;
        wr      = seed_we_i | xfer;
        cand    = seed_we_i ? seed_i : adv;
        zero    = wr && (cand == '0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fsm      <= IDLE;
            lfsr     <= SEED;
            count_o  <= '0;
            lockup_o <= 1'b0;
        end else begin
            fsm      <= fsm_nxt;
            lockup_o <= zero;
            if (wr)
                lfsr <= zero ? SEED : cand;
            if (seed_we_i)
                count_o <= '0;
            else if (xfer)
                count_o <= count_o + 32'd1;
        end
    end

    assign valid_o = (fsm == RUN);
    assign data_o  = lfsr[OUT_W-1:0];
    assign state_o = lfsr;

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: randomized check of a 1-step and an 8-step lfsr_stream against a behavioural model.
module tb_lfsr_stream;

    localparam logic [31:0] TAPS = 32'h088C8892;
    localparam logic [31:0] SEED = 32'd12403728;

    logic        clk_i = 1'b0, reset_i = 1'b1, en_i = 1'b0, seed_we_i = 1'b0, ready_i = 1'b0;
    logic [31:0] seed_i = '0;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_lock, b_lock;
    logic [31:0] a_count, b_count, a_state, b_state;

    int checks = 0, failures = 0, words_b = 0;

    logic [31:0] m_state [2];
    logic [31:0] m_count [2];
    logic        m_lock  [2];
    logic        m_valid;

    lfsr_stream dut_a (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .seed_we_i(seed_we_i), .seed_i(seed_i),
        .data_o(a_data), .valid_o(a_valid), .ready_i(ready_i), .lockup_o(a_lock),
        .count_o(a_count), .state_o(a_state)
    );

    lfsr_stream #(.STEPS(8), .OUT_W(8)) dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .seed_we_i(seed_we_i), .seed_i(seed_i),
        .data_o(b_data), .valid_o(b_valid), .ready_i(ready_i), .lockup_o(b_lock),
        .count_o(b_count), .state_o(b_state)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] adv(input logic [31:0] s, input int n);
        for (int k = 0; k < n; k++)
            s = (s << 1) | 32'($countones(s & TAPS) % 2);
        return s;
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] = SEED;
                m_count[i] = 0;
                m_lock[i]  = 1'b0;
            end
            m_valid = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] w;
                logic        write;
                write = seed_we_i || (m_valid && ready_i);
                w     = seed_we_i ? seed_i : adv(m_state[i], i == 0 ? 1 : 8);
                if (seed_we_i)
                    m_count[i] = 0;
                else if (m_valid && ready_i)
                    m_count[i] = m_count[i] + 1;
                if (i == 1 && m_valid && ready_i)
                    words_b++;
                m_lock[i] = write && (w == 0);
                if (write)
                    m_state[i] = (w == 0) ? SEED : w;
            end
            m_valid = en_i;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_data",  32'(a_data),  32'(m_state[0][7:0]));
        chk("a_state", a_state,      m_state[0]);
        chk("a_count", a_count,      m_count[0]);
        chk("a_valid", 32'(a_valid), 32'(m_valid));
        chk("a_lock",  32'(a_lock),  32'(m_lock[0]));
        chk("b_data",  32'(b_data),  32'(m_state[1][7:0]));
        chk("b_state", b_state,      m_state[1]);
        chk("b_count", b_count,      m_count[1]);
        chk("b_valid", 32'(b_valid), 32'(m_valid));
        chk("b_lock",  32'(b_lock),  32'(m_lock[1]));
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            en_i      = $urandom_range(0, 9) != 0;
            ready_i   = $urandom_range(0, 3) != 0;
            seed_we_i = $urandom_range(0, 63) == 0;
            seed_i    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            @(negedge clk_i);
            check_all();
        end
    endtask

    initial begin
        #12;
        chk("rst_data",  32'(a_data),  32'h10);
        chk("rst_state", a_state,      SEED);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_count", a_count,      32'd0);
        chk("rst_lock",  32'(a_lock),  32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        en_i    = 1'b1;
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("run_valid", 32'(a_valid), 32'd1);
        chk("run_data0", 32'(a_data),  32'h10);
        check_all();
        @(negedge clk_i);
        chk("run_data1",  32'(a_data), 32'h20);
        chk("run_state1", a_state,     32'h017A8820);
        chk("run_count1", a_count,     32'd1);
        chk("b_state1",   b_state,     adv(SEED, 8));
        check_all();
        ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            chk("hold_data",  32'(a_data), 32'h20);
            chk("hold_count", a_count,     32'd1);
            check_all();
        end
        ready_i = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            check_all();
        end
        chk("b2b_count", a_count, 32'd11);
        chk("b2b_state", a_state, adv(SEED, 11));
        seed_we_i = 1'b1;
        seed_i    = 32'hDEADBEEF;
        @(negedge clk_i);
        seed_we_i = 1'b0;
        ready_i   = 1'b0;
        chk("seed_state", a_state, 32'hDEADBEEF);
        chk("seed_count", a_count, 32'd0);
        chk("seed_bstate", b_state, 32'hDEADBEEF);
        check_all();
        seed_we_i = 1'b1;
        seed_i    = 32'd0;
        @(negedge clk_i);
        seed_we_i = 1'b0;
        chk("lock_state", a_state,     SEED);
        chk("lock_pulse", 32'(a_lock), 32'd1);
        check_all();
        @(negedge clk_i);
        chk("lock_end", 32'(a_lock), 32'd0);
        check_all();
        rand_cycles(1000);
        en_i    = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_count", a_count,      32'd0);
        chk("arst_data",  32'(a_data),  32'h10);
        chk("arst_bdata", 32'(b_data),  32'h10);
        @(negedge clk_i);
        check_all();
        reset_i = 1'b0;
        rand_cycles(1000);
        chk("b_words_enough", 32'(words_b >= 1000), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
